// File: rtl/twiddle_addr_gen.sv
// Twiddle ROM address sequencer for an in-place NTT/INTT butterfly array.
// Issues two twiddle addresses per pair, stage-major, with 1-cycle ROM tags.
module twiddle_addr_gen #(
  parameter int LOG_N  = 8,
  parameter int ADDR_W = LOG_N + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       mode,
  input  logic                       adv,
  output logic                       rom_en,
  output logic [ADDR_W-1:0]          rom_addra,
  output logic [ADDR_W-1:0]          rom_addrb,
  output logic                       tw_valid,
  output logic [$clog2(LOG_N)-1:0]   tw_stage,
  output logic                       tw_last,
  output logic                       busy,
  output logic                       done
);

  localparam int N  = 1 << LOG_N;
  localparam int TW = $clog2(LOG_N);
  localparam int CW = LOG_N - 2;
  localparam int BW = LOG_N - 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [TW-1:0]   t;
  logic [CW-1:0]   c;
  logic            mode_q;
  logic            t_last;
  logic            c_last;
  logic            final_issue;
  logic [TW-1:0]   s;
  logic [BW-1:0]   b0;
  logic [BW-1:0]   b1;

  // base + 2^s + (b >> (LOG_N-1-s))
  function automatic logic [ADDR_W-1:0] tw_addr(
    input logic [BW-1:0] b,
    input logic [TW-1:0] st,
    input logic          m
  );
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] pw;
    logic [ADDR_W-1:0] off;
    logic [TW-1:0]     sh;
    base = m ? ADDR_W'(N) : '0;
    pw   = ADDR_W'(1) << st;
    sh   = TW'(LOG_N - 1) - st;
    off  = ADDR_W'(b) >> sh;
    return base + pw + off;
  endfunction

  assign t_last      = (t == TW'(LOG_N - 1));
  assign c_last      = (c == {CW{1'b1}});
  assign final_issue = (state == RUN) && adv &&
                       t_last && c_last;

  assign s  = mode_q ? (TW'(LOG_N - 1) - t) : t;
  assign b0 = {c, 1'b0};
  assign b1 = {c, 1'b1};

  assign rom_addra = (state == RUN) ?
                     tw_addr(b0, s, mode_q) : '0;
  assign rom_addrb = (state == RUN) ?
                     tw_addr(b1, s, mode_q) : '0;

  always_comb begin
    state_nx = state;
    rom_en   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy   = 1'b1;
        rom_en = adv;
        if (final_issue) state_nx = DRAIN;
      end
      DRAIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      t        <= '0;
      c        <= '0;
      mode_q   <= 1'b0;
      tw_valid <= 1'b0;
      tw_stage <= '0;
      tw_last  <= 1'b0;
    end else begin
      state    <= state_nx;
      tw_valid <= rom_en;
      tw_stage <= t;
      tw_last  <= final_issue;
      if (state == IDLE && start) begin
        t      <= '0;
        c      <= '0;
        mode_q <= mode;
      end else if (rom_en) begin
        if (final_issue) begin
          t <= '0;
          c <= '0;
        end else if (c_last) begin
          t <= t + TW'(1);
          c <= '0;
        end else begin
          c <= c + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// Scoreboard bench for twiddle_addr_gen: default N=256 instance plus
// a LOG_N=3 instance checked against a hand-built table.
module tb_twiddle_addr_gen;

  localparam int AW = 9;
  localparam int TW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic adv = 1'b0;
  logic rom_en, tw_valid, tw_last, busy, done;
  logic [AW-1:0] rom_addra, rom_addrb;
  logic [TW-1:0] tw_stage;

  logic start3 = 1'b0;
  logic rom_en3, tw_valid3, tw_last3, busy3, done3;
  logic [3:0] addra3, addrb3;
  logic [1:0] tw_stage3;

  always #5 clk = ~clk;

  twiddle_addr_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mode(mode), .adv(adv), .rom_en(rom_en),
    .rom_addra(rom_addra), .rom_addrb(rom_addrb),
    .tw_valid(tw_valid), .tw_stage(tw_stage),
    .tw_last(tw_last), .busy(busy), .done(done)
  );

  twiddle_addr_gen #(.LOG_N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .mode(1'b0), .adv(1'b1), .rom_en(rom_en3),
    .rom_addra(addra3), .rom_addrb(addrb3),
    .tw_valid(tw_valid3), .tw_stage(tw_stage3),
    .tw_last(tw_last3), .busy(busy3), .done(done3)
  );

  typedef struct {
    int k; bit m; int a; int b; int st; bit last;
  } rec_t;

  rec_t aq[$];
  rec_t sq[$];
  int   q3a[$];
  int   q3b[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_iss = 0;
  int   n_twv = 0;
  int   n_done = 0;
  int   n_iss3 = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic rec_t mk(int k, bit m);
    rec_t r;
    int t, c, s, base;
    t = k / 64;
    c = k % 64;
    s = m ? 7 - t : t;
    base = m ? 256 : 0;
    r.k = k;
    r.m = m;
    r.a = base + (1 << s) + ((2 * c) >> (7 - s));
    r.b = base + (1 << s) + ((2 * c + 1) >> (7 - s));
    r.st = t;
    r.last = (k == 511);
    return r;
  endfunction

  task automatic push_all(bit m);
    for (int k = 0; k < 512; k++) begin
      aq.push_back(mk(k, m));
      sq.push_back(mk(k, m));
    end
  endtask

  logic pv_busy = 1'b0;
  logic pv_en = 1'b0;
  logic [AW-1:0] pv_a = '0;
  logic [AW-1:0] pv_b = '0;

  always @(negedge clk) begin
    rec_t r;
    if (rom_en) begin
      n_iss++;
      if (aq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL issue_unexpected: got %0d,%0d expected none",
                 rom_addra, rom_addrb);
      end else begin
        r = aq.pop_front();
        chk("addra", rom_addra, r.a);
        chk("addrb", rom_addrb, r.b);
        if (!r.m && r.k == 0) begin
          chk("fwd0_a", rom_addra, 1); chk("fwd0_b", rom_addrb, 1);
        end
        if (!r.m && r.k == 64) begin
          chk("fwd64_a", rom_addra, 2); chk("fwd64_b", rom_addrb, 2);
        end
        if (!r.m && r.k == 96) begin
          chk("fwd96_a", rom_addra, 3); chk("fwd96_b", rom_addrb, 3);
        end
        if (!r.m && r.k == 511) begin
          chk("fwd511_a", rom_addra, 254);
          chk("fwd511_b", rom_addrb, 255);
        end
        if (r.m && r.k == 0) begin
          chk("inv0_a", rom_addra, 384); chk("inv0_b", rom_addrb, 385);
        end
        if (r.m && r.k == 511) begin
          chk("inv511_a", rom_addra, 257);
          chk("inv511_b", rom_addrb, 257);
        end
      end
    end
    if (busy && pv_busy && !pv_en) begin
      chk("hold_a", rom_addra, pv_a);
      chk("hold_b", rom_addrb, pv_b);
    end
    if (tw_valid) begin
      n_twv++;
      if (sq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL tw_valid_unexpected: got 1 expected 0");
      end else begin
        r = sq.pop_front();
        chk("tw_stage", tw_stage, r.st);
        chk("tw_last", tw_last, r.last);
      end
    end
    if (done) begin
      n_done++;
      chk("done_tw_valid", tw_valid, 1);
      chk("done_tw_last", tw_last, 1);
      chk("done_busy", busy, 0);
    end
    pv_busy = busy;
    pv_en = rom_en;
    pv_a = rom_addra;
    pv_b = rom_addrb;
  end

  always @(negedge clk) begin
    if (rom_en3) begin
      n_iss3++;
      if (q3a.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL n8_issue_unexpected: got %0d expected none",
                 addra3);
      end else begin
        chk("n8_addra", addra3, q3a.pop_front());
        chk("n8_addrb", addrb3, q3b.pop_front());
      end
    end
  end

  task automatic do_start(bit m);
    push_all(m);
    start = 1'b1;
    mode = m;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic finish_xfer(int twv0, int d0);
    @(posedge clk);
    #1;
    chk("tw_valid_count", n_twv - twv0, 512);
    chk("done_count", n_done - d0, 1);
    chk("aq_empty", aq.size(), 0);
    chk("sq_empty", sq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int twv0, d0, i0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rom_en", rom_en, 0);
    chk("rst_addra", rom_addra, 0);
    chk("rst_addrb", rom_addrb, 0);
    chk("rst_tw_valid", tw_valid, 0);
    chk("rst_tw_stage", tw_stage, 0);
    chk("rst_tw_last", tw_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    adv = 1'b1;

    // forward, adv held high
    @(negedge clk);
    chk("idle_addra", rom_addra, 0);
    chk("idle_addrb", rom_addrb, 0);
    @(posedge clk);
    #1;
    twv0 = n_twv; d0 = n_done;
    do_start(0);
    @(negedge clk);
    chk("first_busy", busy, 1);
    chk("first_rom_en", rom_en, 1);
    wait_done(600);
    finish_xfer(twv0, d0);

    // inverse
    twv0 = n_twv; d0 = n_done;
    do_start(1);
    wait_done(600);
    finish_xfer(twv0, d0);

    // random adv gaps
    twv0 = n_twv; d0 = n_done;
    do_start(0);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk);
      #1 adv = 1'($urandom_range(0, 1));
    end
    chk("rnd_done_seen", done, 1);
    adv = 1'b1;
    finish_xfer(twv0, d0);

    // reset mid-transform
    d0 = n_done; i0 = n_iss;
    do_start(0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_iss - i0 >= 100) break;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rom_en", rom_en, 0);
    chk("abort_addra", rom_addra, 0);
    chk("abort_addrb", rom_addrb, 0);
    chk("abort_tw_valid", tw_valid, 0);
    chk("abort_tw_stage", tw_stage, 0);
    chk("abort_tw_last", tw_last, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    aq.delete();
    sq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_no_done", n_done - d0, 0);
    twv0 = n_twv; d0 = n_done;
    do_start(0);
    wait_done(600);
    finish_xfer(twv0, d0);

    // start while busy and at done ignored; next cycle accepted
    twv0 = n_twv; d0 = n_done;
    do_start(0);
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    mode = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(600);
    start = 1'b1;
    mode = 1'b1;
    @(posedge clk);
    #1;
    chk("tw_valid_count", n_twv - twv0, 512);
    chk("done_count", n_done - d0, 1);
    chk("aq_empty", aq.size(), 0);
    twv0 = n_twv; d0 = n_done;
    push_all(1);
    @(negedge clk);
    chk("start_at_done_busy", busy, 0);
    chk("start_at_done_rom_en", rom_en, 0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("start_after_done_busy", busy, 1);
    wait_done(600);
    finish_xfer(twv0, d0);

    // LOG_N=3 hand table
    q3a = '{1, 1, 2, 3, 4, 6};
    q3b = '{1, 1, 2, 3, 5, 7};
    i0 = n_iss3;
    start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done3) break;
    end
    chk("n8_done", done3, 1);
    chk("n8_tw_last", tw_last3, 1);
    chk("n8_tw_stage", tw_stage3, 2);
    @(posedge clk);
    #1;
    chk("n8_issues", n_iss3 - i0, 6);
    chk("n8_queue_empty", q3a.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/twiddle_addr_gen.md
TWIDDLE_ADDR_GEN -- requirements
Module: twiddle_addr_gen

Interface
REQ-001 Parameter: LOG_N, default 8, log2 of polynomial length N (N=256); legal range 3..10.
REQ-002 Parameter: ADDR_W, default LOG_N+1, twiddle ROM address width. ROM depth is 2N: forward zetas at 0..N-1, inverse zetas at N..2N-1.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 start  in  1  one-cycle request to begin a transform; sampled only in IDLE.
REQ-006 mode  in  1  0 = forward NTT, 1 = inverse NTT; captured with start.
REQ-007 adv  in  1  butterfly datapath ready; an issue occurs only when adv=1.
REQ-008 rom_en  out  1  ROM read enable; high exactly on issue cycles.
REQ-009 rom_addra  out  ADDR_W  twiddle address for even butterfly of current pair.
REQ-010 rom_addrb  out  ADDR_W  twiddle address for odd butterfly of current pair.
REQ-011 tw_valid  out  1  ROM outputs valid this cycle (rom_en delayed 1 cycle).
REQ-012 tw_stage  out  $clog2(LOG_N)  stage index of data under tw_valid.
REQ-013 tw_last  out  1  high with tw_valid on final pair of final stage.
REQ-014 busy  out  1  high from accepted start until done.
REQ-015 done  out  1  one-cycle completion pulse.

Function
REQ-016 FSM states: IDLE, RUN, DRAIN. IDLE->RUN on start=1; RUN->DRAIN on the final issue; DRAIN->IDLE after one cycle.
REQ-017 RUN iterates stage counter t = 0..LOG_N-1 (outer) and pair counter c = 0..N/4-1 (inner); both advance only on issue cycles; c wraps to 0 and t increments when c = N/4-1.
REQ-018 Physical stage s = t for mode 0, s = LOG_N-1-t for mode 1.
REQ-019 Butterfly indices: even b0 = 2c, odd b1 = 2c+1, each in 0..N/2-1.
REQ-020 Address = base + 2^s + (b >> (LOG_N-1-s)), base = 0 for mode 0, N for mode 1; computed at ADDR_W bits, no overflow for legal parameters.
REQ-021 rom_addra/rom_addrb are combinational from the current counters and mode, and are valid whenever rom_en=1; rom_en = (state==RUN) && adv.
REQ-022 adv=0 in RUN freezes counters and holds addresses; rom_en=0.
REQ-023 tw_valid, tw_stage, tw_last are registered copies of rom_en, t, and final-issue flag; latency 1 cycle, matching the 1-stage ROM.
REQ-024 done asserts in the DRAIN cycle, coincident with tw_valid=1 and tw_last=1; busy deasserts the same cycle.
REQ-025 start while busy is ignored; mode changes while busy have no effect.
REQ-026 Total issues per transform = LOG_N*N/4 (512 at defaults).

Reset
REQ-027 rst_n=0 at a clock edge forces IDLE and clears t, c, the captured mode, rom_en, tw_valid, tw_stage, tw_last, busy and done to 0, regardless of the current state.
REQ-028 Reset mid-transform aborts it; no done pulse; the next start begins at t=0, c=0.
REQ-029 In IDLE, rom_addra and rom_addrb are 0.

Verification
REQ-030 Forward, adv=1 constant: start -> first issue next cycle with addra=addrb=1; stage 1 c=0 gives 2,2; c=32 gives 3,3; stage 7 c=63 gives 254,255; 512 issues.
REQ-031 Inverse: start with mode=1 -> first issue addra=384, addrb=385, tw_stage=0; last issue 257,257; done coincident with tw_last.
REQ-032 Random adv gaps: addresses hold while adv=0, sequence identical to REQ-030, tw_valid count = 512, exactly one done.
REQ-033 Assert rst_n=0 at issue 100 -> all outputs 0 next cycle, no done; a new start replays the sequence from address 1.
REQ-034 start pulsed during RUN and at the done cycle -> ignored; start in the cycle after done -> accepted.
REQ-035 LOG_N=3 (N=8): forward sequence of 6 issues: (1,1),(1,1),(2,2),(3,3),(4,5),(6,7).
